// File: rtl/piso_serializer.sv
// ---------------------------------------------------------------------------
// PisoSerializer (module piso_serializer)
//
// Parallel-in, serial-out serializer. A word offered on the valid/ready load
// port is shifted out one bit per enabled cycle, MSB first (dir = 0) or LSB
// first (dir = 1). The last-bit cycle can overlap with the next accept, so
// back-to-back words stream without a gap. The en input freezes the bit
// stream on any cycle.
//
// Ports
//   clk         rising-edge clock
//   rstn        asynchronous active-low reset
//   in_valid    in_data/dir offered for load
//   in_ready    block can accept a word this cycle (combinational on en/rstn)
//   in_data     parallel word to serialize
//   dir         0 = MSB first, 1 = LSB first; sampled only on accept
//   en          shift enable; 0 holds the current bit and all state
//   sout        serial data bit (0 while idle)
//   sout_valid  sout carries a word bit
//   busy        a word is in flight
//   done        one-cycle pulse after the last bit of a word is consumed
// ---------------------------------------------------------------------------
module piso_serializer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             dir,
    input  logic             en,
    output logic             sout,
    output logic             sout_valid,
    output logic             busy,
    output logic             done
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic             dir_q, dir_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             done_q, done_d;

    logic lastBit;
    logic accept;

    // The last bit is consumed only when the counter sits on the final
    // position and the shift is enabled; this is also the one cycle in
    // SHIFT where a new word may be accepted without a bubble.
    assign lastBit  = (state_q == SHIFT) && (cnt_q == LAST_CNT) && en;
    assign in_ready = rstn && ((state_q == IDLE) || lastBit);
    assign accept   = in_valid && in_ready;

    // Next-state logic. Everything holds by default, so an en = 0 cycle in
    // SHIFT freezes the word. A load overrides the shift/clear decisions
    // because an accept can only coincide with IDLE or the last-bit cycle.
    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        dir_d   = dir_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;

        case (state_q)
            IDLE: begin
                state_d = IDLE;
            end
            SHIFT: begin
                if (en) begin
                    if (dir_q) begin
                        shreg_d = {1'b0, shreg_q[WIDTH-1:1]};
                    end else begin
                        shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
                    end
                    if (cnt_q == LAST_CNT) begin
                        done_d  = 1'b1;
                        state_d = IDLE;
                        shreg_d = '0;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (accept) begin
            state_d = SHIFT;
            shreg_d = in_data;
            dir_d   = dir;
            cnt_d   = '0;
        end
    end

    // State register; reset abandons any word in flight without a done pulse.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
            shreg_q <= '0;
            dir_q   <= 1'b0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            dir_q   <= dir_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
        end
    end

    // Outputs come straight from registers so downstream logic sees no
    // combinational path from the inputs.
    always_comb begin
        sout = 1'b0;
        if (state_q == SHIFT) begin
            sout = dir_q ? shreg_q[0] : shreg_q[WIDTH-1];
        end
    end

    assign sout_valid = (state_q == SHIFT);
    assign busy       = (state_q == SHIFT);
    assign done       = done_q;

endmodule

// File: tb/tb_piso_serializer.sv
// ---------------------------------------------------------------------------
// Testbench for piso_serializer. A driver issues directed and random words;
// each accepted word is expanded into its expected bit sequence and pushed
// into a scoreboard queue. An independent monitor on the falling edge pops
// bits as they are consumed, checks handshake/status outputs, and feeds a
// behavioural receiving shift register whose contents must equal the word
// when done pulses.
// ---------------------------------------------------------------------------
module tb_piso_serializer;

    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             rstn;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             dir;
    logic             en;
    logic             sout;
    logic             sout_valid;
    logic             busy;
    logic             done;

    typedef struct {
        logic             b;
        logic             last;
        logic [WIDTH-1:0] word;
        logic             d;
    } exp_t;

    exp_t             bitQ[$];
    int               errors = 0;
    int               checks = 0;
    logic             accPend = 1'b0;
    logic [WIDTH-1:0] pendData;
    logic             pendDir;
    logic             expDone = 1'b0;
    logic [WIDTH-1:0] doneWord = '0;
    logic [WIDTH-1:0] rx = '0;

    piso_serializer #(.WIDTH(WIDTH)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .dir        (dir),
        .en         (en),
        .sout       (sout),
        .sout_valid (sout_valid),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s: actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    // Reference model: a word transmitted with dir becomes WIDTH bits, taken
    // from the top index downwards (dir = 0) or from index 0 upwards (dir = 1).
    function automatic void pushWord(input logic [WIDTH-1:0] data, input logic d);
        exp_t e;
        for (int i = 0; i < WIDTH; i++) begin
            e.b    = d ? data[i] : data[WIDTH-1-i];
            e.last = (i == WIDTH - 1);
            e.word = data;
            e.d    = d;
            bitQ.push_back(e);
        end
    endfunction

    // One driver cycle: publish the previous cycle's accept to the
    // scoreboard, drive new inputs after the edge, then note whether the
    // handshake completes at the coming edge.
    task automatic applyStimulus(input logic v, input logic [WIDTH-1:0] data,
                                 input logic d, input logic e);
        @(posedge clk);
        #1;
        if (accPend) begin
            pushWord(pendData, pendDir);
            accPend = 1'b0;
        end
        in_valid = v;
        in_data  = data;
        dir      = d;
        en       = e;
        #1;
        if (in_valid && in_ready) begin
            accPend  = 1'b1;
            pendData = in_data;
            pendDir  = dir;
        end
    endtask

    // Monitor: compares every output against the scoreboard each cycle, then
    // consumes a bit (and shifts the loopback receiver) when en is high.
    always @(negedge clk) begin
        if (rstn === 1'b1) begin
            exp_t e;
            checkOutput("in_ready", {31'd0, in_ready},
                        {31'd0, (bitQ.size() == 0) || (bitQ.size() == 1 && en)});
            checkOutput("sout_valid", {31'd0, sout_valid}, {31'd0, bitQ.size() != 0});
            checkOutput("busy", {31'd0, busy}, {31'd0, bitQ.size() != 0});
            checkOutput("done", {31'd0, done}, {31'd0, expDone});
            if (expDone) begin
                checkOutput("loopback", {24'd0, rx}, {24'd0, doneWord});
            end
            expDone = 1'b0;
            if (bitQ.size() != 0) begin
                e = bitQ[0];
                checkOutput("sout", {31'd0, sout}, {31'd0, e.b});
                if (en) begin
                    rx = e.d ? {sout, rx[WIDTH-1:1]} : {rx[WIDTH-2:0], sout};
                    void'(bitQ.pop_front());
                    if (e.last) begin
                        expDone  = 1'b1;
                        doneWord = e.word;
                    end
                end
            end else begin
                checkOutput("sout_idle", {31'd0, sout}, 32'd0);
            end
        end
    end

    // Asynchronous reset in the middle of a cycle, checked before any edge.
    task automatic resetMid();
        @(posedge clk);
        #3;
        rstn     = 1'b0;
        in_valid = 1'b0;
        #1;
        checkOutput("rst_sout", {31'd0, sout}, 32'd0);
        checkOutput("rst_sout_valid", {31'd0, sout_valid}, 32'd0);
        checkOutput("rst_busy", {31'd0, busy}, 32'd0);
        checkOutput("rst_done", {31'd0, done}, 32'd0);
        checkOutput("rst_in_ready", {31'd0, in_ready}, 32'd0);
        bitQ.delete();
        accPend = 1'b0;
        expDone = 1'b0;
        @(posedge clk);
        #3;
        checkOutput("rst_hold_busy", {31'd0, busy}, 32'd0);
        rstn = 1'b1;
        #1;
        checkOutput("rst_release_ready", {31'd0, in_ready}, 32'd1);
    endtask

    initial begin
        rstn     = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        dir      = 1'b0;
        en       = 1'b0;
        #2;
        checkOutput("init_sout_valid", {31'd0, sout_valid}, 32'd0);
        checkOutput("init_in_ready", {31'd0, in_ready}, 32'd0);
        @(posedge clk);
        #3;
        rstn = 1'b1;
        #1;
        checkOutput("init_release_ready", {31'd0, in_ready}, 32'd1);

        // MSB first
        applyStimulus(1'b1, 8'h1E, 1'b0, 1'b1);
        repeat (10) applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);

        // LSB first, dir toggled after the accept
        applyStimulus(1'b1, 8'h1E, 1'b1, 1'b1);
        for (int i = 0; i < 10; i++) applyStimulus(1'b0, 8'h00, i[0], 1'b1);

        // Stall for 3 cycles after bit 2
        applyStimulus(1'b1, 8'h1E, 1'b0, 1'b1);
        repeat (3) applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
        repeat (3) applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
        repeat (8) applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);

        // Back-to-back: second word offered continuously until accepted
        applyStimulus(1'b1, 8'hA5, 1'b0, 1'b1);
        repeat (8) applyStimulus(1'b1, 8'h3C, 1'b0, 1'b1);
        repeat (10) applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);

        // Reset while a word is in flight
        applyStimulus(1'b1, 8'hC3, 1'b1, 1'b1);
        repeat (3) applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
        resetMid();

        // Random words, directions, enables and valids
        for (int i = 0; i < 400; i++) begin
            applyStimulus(($urandom_range(0, 9) < 7), WIDTH'($urandom), 1'($urandom),
                          ($urandom_range(0, 3) != 0));
        end

        // Drain, bounded
        begin
            int budget;
            budget = 0;
            while ((bitQ.size() != 0 || accPend) && budget < 40) begin
                applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
                budget++;
            end
            if (bitQ.size() != 0 || accPend) begin
                checkOutput("drain_timeout", 32'd1, 32'd0);
            end
        end
        repeat (3) applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
